// File: rtl/pool_requant_wr_pkg.sv
// Shared widths, FSM encoding and the int8 saturation helper for the
// pooling requantize/write-back stage.
package pool_requant_wr_pkg;

    localparam int LANE_W  = 14;  // signed pool result per lane
    localparam int OUT_W   = 8;   // signed int8 output per lane
    localparam int MULT_W  = 16;  // unsigned requant multiplier
    localparam int SHIFT_W = 5;   // rounding right-shift amount
    localparam int PROD_W  = 31;  // signed 14 x signed 17 product
    localparam int SUM_W   = 32;  // product plus rounding constant (up to 2^30)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Clamp a full-width signed value to [-128, 127] and return its 8 bits.
    function automatic logic [OUT_W-1:0] sat_int8(input logic signed [SUM_W:0] v);
        logic [OUT_W-1:0] res;
        if (v > 33'sd127) begin
            res = 8'h7F;
        end else if (v < -33'sd128) begin
            res = 8'h80;
        end else begin
            res = v[OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/pool_requant_lane.sv
// Per-lane 3-stage requantizer: multiply, rounding arithmetic shift,
// zero-point add with int8 saturation. Valids live in the parent; the
// stage enables only gate register updates.
module pool_requant_lane
    import pool_requant_wr_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_en1,
    input  logic               i_en2,
    input  logic               i_en3,
    input  logic [LANE_W-1:0]  i_y,
    input  logic [MULT_W-1:0]  i_m,
    input  logic [SHIFT_W-1:0] i_s,
    input  logic [OUT_W-1:0]   i_zp,
    output logic [OUT_W-1:0]   o_q
);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] r_p;
    logic signed [SUM_W-1:0]  w_rnd;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [SUM_W-1:0]  w_shr;
    logic signed [SUM_W-1:0]  r_r;
    logic signed [SUM_W:0]    w_q;
    logic [OUT_W-1:0]         r_q;

    // Both operands sign/zero-extended to the product width so nothing wraps.
    assign w_prod = $signed({{(PROD_W-LANE_W){i_y[LANE_W-1]}}, i_y})
                  * $signed({{(PROD_W-MULT_W){1'b0}}, i_m});

    // Round half up toward +inf, then arithmetic shift; s==0 passes through.
    always_comb begin
        w_rnd = 32'sd0;
        if (i_s != 5'd0) begin
            w_rnd = $signed(32'd1 << (i_s - 5'd1));
        end else begin
            w_rnd = 32'sd0;
        end
        w_sum = $signed({r_p[PROD_W-1], r_p}) + w_rnd;
        if (i_s != 5'd0) begin
            w_shr = w_sum >>> i_s;
        end else begin
            w_shr = $signed({r_p[PROD_W-1], r_p});
        end
    end

    // Zero point added one bit wider than the shifted value before clamping.
    assign w_q = $signed({r_r[SUM_W-1], r_r})
               + $signed({{(SUM_W+1-OUT_W){i_zp[OUT_W-1]}}, i_zp});

    // Pipeline registers, each advancing only when its stage holds a vector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_p <= '0;
            r_r <= '0;
            r_q <= '0;
        end else begin
            if (i_en1) begin
                r_p <= w_prod;
            end
            if (i_en2) begin
                r_r <= w_shr;
            end
            if (i_en3) begin
                r_q <= sat_int8(w_q);
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pool_requant_wr.sv
// Requantize LANES pool results per accepted vector and write the packed
// int8 word to consecutive output-buffer addresses; pulse done at the end.
module pool_requant_wr
    import pool_requant_wr_pkg::*;
#(
    parameter int LANES  = 32,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       cfg_base,
    input  logic [CNT_W-1:0]        cfg_n_vec,
    input  logic [MULT_W-1:0]       cfg_m,
    input  logic [SHIFT_W-1:0]      cfg_s,
    input  logic [OUT_W-1:0]        cfg_zp,
    input  logic [LANES*LANE_W-1:0] ys,
    input  logic                    y_vld,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [LANES*OUT_W-1:0]  wr_data,
    output logic                    busy,
    output logic                    done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    r_base;
    logic [CNT_W-1:0]     r_n_vec;
    logic [MULT_W-1:0]    r_m;
    logic [SHIFT_W-1:0]   r_s;
    logic [OUT_W-1:0]     r_zp;
    logic [CNT_W-1:0]     r_in_cnt;
    logic [CNT_W-1:0]     r_out_cnt;
    logic [CNT_W-1:0]     w_out_cnt_nxt;
    logic                 r_v1;
    logic                 r_v2;
    logic                 r_wr_en;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_acc;
    logic                 w_start_ok;
    logic                 w_last_in;
    logic [LANES*OUT_W-1:0] w_lane_q;

    assign w_acc         = (r_state == ST_RUN) && y_vld;
    assign w_start_ok    = (r_state == ST_IDLE) && start;
    assign w_last_in     = (r_in_cnt == (r_n_vec - CNT_ONE));
    assign w_out_cnt_nxt = r_v2 ? (r_out_cnt + CNT_ONE) : r_out_cnt;

    // Next-state logic. DRAIN leaves on the edge that issues the last write
    // so that done (registered from DONE) lands the cycle after that write.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_n_vec != {CNT_W{1'b0}}) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_acc && w_last_in) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((w_out_cnt_nxt == r_n_vec) && !r_v1) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (r_state == ST_DONE);
        end
    end

    // Configuration latch and vector counters, both rearmed by start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base    <= '0;
            r_n_vec   <= '0;
            r_m       <= '0;
            r_s       <= '0;
            r_zp      <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (w_start_ok) begin
            r_base    <= cfg_base;
            r_n_vec   <= cfg_n_vec;
            r_m       <= cfg_m;
            r_s       <= cfg_s;
            r_zp      <= cfg_zp;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_acc) begin
                r_in_cnt <= r_in_cnt + CNT_ONE;
            end
            r_out_cnt <= w_out_cnt_nxt;
        end
    end

    // Stage valids and the write strobe/address of the final stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_v1    <= w_acc;
            r_v2    <= r_v1;
            r_wr_en <= r_v2;
            if (r_v2) begin
                r_wr_addr <= r_base + ADDR_W'(r_out_cnt);
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pool_requant_lane u_lane (
            .clk   (clk),
            .rstn  (rstn),
            .i_en1 (w_acc),
            .i_en2 (r_v1),
            .i_en3 (r_v2),
            .i_y   (ys[g*LANE_W +: LANE_W]),
            .i_m   (r_m),
            .i_s   (r_s),
            .i_zp  (r_zp),
            .o_q   (w_lane_q[g*OUT_W +: OUT_W])
        );
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = w_lane_q;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_pool_requant_wr.sv
// Directed bench for pool_requant_wr with a write scoreboard.
module tb_pool_requant_wr;

    localparam int LANES = 32;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [15:0]      cfg_base;
    logic [15:0]      cfg_n_vec;
    logic [15:0]      cfg_m;
    logic [4:0]       cfg_s;
    logic [7:0]       cfg_zp;
    logic [LANES*14-1:0] ys;
    logic             y_vld;
    logic             wr_en;
    logic [15:0]      wr_addr;
    logic [LANES*8-1:0] wr_data;
    logic             busy;
    logic             done;

    typedef struct {
        int           period;
        logic [15:0]  addr;
        logic [255:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_wr_period = -1;
    int   done_period    = -1;
    int   start_period   = 0;
    bit   got_done       = 0;
    int   cur_m, cur_s, cur_zp, wr_idx;
    logic [15:0] cur_base;
    int   dp;

    pool_requant_wr #(.LANES(LANES), .ADDR_W(16), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_base(cfg_base),
        .cfg_n_vec(cfg_n_vec), .cfg_m(cfg_m), .cfg_s(cfg_s), .cfg_zp(cfg_zp),
        .ys(ys), .y_vld(y_vld), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requant reference: floor((p + 2^(s-1)) / 2^s) via integer division.
    function automatic logic [7:0] lane_model(input int y, input int m, input int s, input int zp);
        longint p, r, d, num, qv;
        p = longint'(y) * longint'(m);
        if (s == 0) begin
            r = p;
        end else begin
            d   = longint'(1) << s;
            num = p + d / 2;
            if (num >= 0) r = num / d;
            else          r = -((-num + d - 1) / d);
        end
        qv = r + zp;
        if (qv > 127)  qv = 127;
        if (qv < -128) qv = -128;
        return 8'(qv);
    endfunction

    function automatic logic [255:0] exp_word(input logic [LANES*14-1:0] v, input int m, input int s, input int zp);
        logic [255:0] w;
        int y;
        w = '0;
        for (int i = 0; i < LANES; i++) begin
            y = $signed(v[i*14 +: 14]);
            w[i*8 +: 8] = lane_model(y, m, s, zp);
        end
        return w;
    endfunction

    function automatic logic [LANES*14-1:0] mk4(input int a, input int b, input int c, input int d);
        logic [LANES*14-1:0] v;
        int vals[4];
        vals = '{a, b, c, d};
        for (int i = 0; i < LANES; i++) v[i*14 +: 14] = 14'(vals[i % 4]);
        return v;
    endfunction

    // One clock: sample #1 after the edge and retire any write against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (wr_en === 1'b1) begin
            last_wr_period = cyc;
            if (q.size() == 0) begin
                chk("unexpected_wr", {255'd0, wr_en}, 256'd0);
            end else begin
                e = q.pop_front();
                chk("wr_period", 256'(cyc), 256'(e.period));
                chk("wr_addr", {240'd0, wr_addr}, {240'd0, e.addr});
                chk("wr_data", wr_data, e.data);
            end
        end
        if (done === 1'b1) begin
            got_done    = 1;
            done_period = cyc;
        end
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] n, input int m,
                            input int s, input int zp, input logic with_vld);
        cfg_base = b; cfg_n_vec = n; cfg_m = 16'(m); cfg_s = 5'(s); cfg_zp = 8'(zp);
        start = 1'b1; y_vld = with_vld; ys = mk4(1000, -1000, 77, -77);
        cur_base = b; cur_m = m; cur_s = s; cur_zp = zp; wr_idx = 0;
        got_done = 0; start_period = cyc;
        tick();
        start = 1'b0; y_vld = 1'b0;
        cfg_base = 16'h5555; cfg_m = 16'h0003; cfg_s = 5'd7; cfg_zp = 8'h11; cfg_n_vec = 16'd9;
        chk("busy_after_start", {255'd0, busy}, 256'd1);
    endtask

    task automatic send(input logic [LANES*14-1:0] v, input bit accept);
        exp_t e;
        ys = v; y_vld = 1'b1;
        if (accept) begin
            e.period = cyc + 3;
            e.addr   = cur_base + 16'(wr_idx);
            e.data   = exp_word(v, cur_m, cur_s, cur_zp);
            q.push_back(e);
            wr_idx++;
        end
        tick();
        y_vld = 1'b0;
    endtask

    task automatic finish_run(input int n);
        for (int i = 0; i < 40 && !got_done; i++) tick();
        chk("done_seen", {255'd0, got_done}, 256'd1);
        dp = done_period;
        if (n != 0) chk("done_after_last_wr", 256'(dp - last_wr_period), 256'd1);
        else        chk("done_after_start", 256'(dp - start_period), 256'd2);
        chk("sb_empty", 256'(q.size()), 256'd0);
        tick();
        chk("done_one_cycle", {255'd0, done}, 256'd0);
        chk("busy_idle", {255'd0, busy}, 256'd0);
    endtask

    task automatic run1(input logic [15:0] b, input int m, input int s, input int zp,
                        input logic [LANES*14-1:0] v);
        do_start(b, 16'd1, m, s, zp, 1'b0);
        send(v, 1);
        finish_run(1);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; y_vld = 1'b0; ys = '0;
        cfg_base = '0; cfg_n_vec = '0; cfg_m = '0; cfg_s = '0; cfg_zp = '0;
        tick(); tick();
        chk("rst_wr_en", {255'd0, wr_en}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_done", {255'd0, done}, 256'd0);
        chk("rst_wr_addr", {240'd0, wr_addr}, 256'd0);
        chk("rst_wr_data", wr_data, 256'd0);
        rstn = 1'b1;
        tick();

        // Identity, y_vld alongside start must be ignored, back-to-back writes.
        do_start(16'h0010, 16'd2, 1, 0, 0, 1'b1);
        send(mk4(5, -7, 5, -7), 1);
        send(mk4(8191, -8192, 0, -1), 1);
        finish_run(2);

        // Rounding average-pool shift.
        do_start(16'h0020, 16'd2, 1, 2, 0, 1'b0);
        send(mk4(6, 5, -6, -5), 1);
        send(mk4(7, -7, 2, -2), 1);
        finish_run(2);

        // Saturation and full-width intermediates.
        run1(16'h0030, 16'hFFFF, 0, 0, mk4(8191, -8192, 1, -1));
        run1(16'h0038, 1, 0, -128, mk4(-1, 0, 5, 127));
        run1(16'h0040, 1, 0, 127, mk4(5, -1, -128, -255));
        run1(16'h0048, 16'hFFFF, 29, 0, mk4(8191, -8192, 4096, -4096));
        run1(16'h0050, 16'hFFFF, 31, 3, mk4(8191, -8192, 1, -1));

        // Gaps, start during RUN, excess vectors, idle y_vld.
        do_start(16'h0060, 16'd3, 3, 1, 4, 1'b0);
        send(mk4(100, -100, 33, -33), 1);
        start = 1'b1; cfg_base = 16'h0099; cfg_m = 16'd7; cfg_n_vec = 16'd1;
        tick();
        start = 1'b0;
        send(mk4(-3, 3, 1, -1), 1);
        send(mk4(4000, -4000, 2, -2), 1);
        send(mk4(9, 9, 9, 9), 0);
        send(mk4(8, 8, 8, 8), 0);
        finish_run(3);
        send(mk4(1, 2, 3, 4), 0);
        send(mk4(1, 2, 3, 4), 0);
        chk("idle_no_busy", {255'd0, busy}, 256'd0);

        // Address wraps modulo 2^16.
        do_start(16'hFFFF, 16'd2, 2, 1, -5, 1'b0);
        send(mk4(10, -10, 11, -11), 1);
        send(mk4(-8192, 8191, 0, 3), 1);
        finish_run(2);

        // Zero vectors.
        do_start(16'h0070, 16'd0, 1, 0, 0, 1'b0);
        finish_run(0);

        // Reset mid-run drops in-flight vectors.
        do_start(16'h0080, 16'd5, 1, 0, 0, 1'b0);
        send(mk4(1, 1, 1, 1), 0);
        send(mk4(2, 2, 2, 2), 0);
        rstn = 1'b0;
        #1;
        chk("midrst_wr_en", {255'd0, wr_en}, 256'd0);
        chk("midrst_busy", {255'd0, busy}, 256'd0);
        chk("midrst_wr_addr", {240'd0, wr_addr}, 256'd0);
        chk("midrst_wr_data", wr_data, 256'd0);
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("post_rst_idle", {255'd0, busy}, 256'd0);
        run1(16'h0090, 1, 0, 0, mk4(42, -42, 0, 13));

        chk("final_sb_empty", 256'(q.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
